// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: NUM_SRC requesting sources on one side, the two register_file write ports on the other.
// master = sources/register_file side, slave = the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 64
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] value;
    } data_t;

    typedef struct packed {
        logic  is_virtual;
        data_t data;
    } register_t;

    logic                    stall;
    logic [NUM_SRC-1:0]      src_valid;
    logic [NUM_SRC-1:0][4:0] src_addr;
    register_t [NUM_SRC-1:0] src_value;
    logic [NUM_SRC-1:0]      src_ready;

    logic [4:0]              write1;
    logic                    write1_enable;
    register_t               write1_value;
    logic [4:0]              write2;
    logic                    write2_enable;
    register_t               write2_value;

    modport master (
        output stall, src_valid, src_addr, src_value,
        input  src_ready,
        input  write1, write1_enable, write1_value,
        input  write2, write2_enable, write2_value
    );

    modport slave (
        input  stall, src_valid, src_addr, src_value,
        output src_ready,
        output write1, write1_enable, write1_value,
        output write2, write2_enable, write2_value
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter: up to two grants per cycle onto register_file write1/write2, never both to one address.
// Latency 1 cycle to the write ports; src_ready is combinational, low in reset/stall, and losers hold valid and retry.
module regfile_wb_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_SRC);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] value;
    } data_t;

    typedef struct packed {
        logic  is_virtual;
        data_t data;
    } register_t;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [PTR_W-1:0]   scan_idx;
    logic [PTR_W-1:0]   a_idx;
    logic [PTR_W-1:0]   b_idx;
    logic [PTR_W-1:0]   last_idx;
    logic [4:0]         a_addr;
    logic               a_vld;
    logic               b_vld;
    logic [NUM_SRC-1:0] ready;

    logic [4:0]         w1_addr;
    logic [4:0]         w2_addr;
    logic               w1_en;
    logic               w2_en;
    register_t          w1_dat;
    register_t          w2_dat;

    // Grant A is the first valid source from ptr; grant B the next one aimed at a different register.
    always_comb begin
        a_vld    = 1'b0;
        b_vld    = 1'b0;
        a_idx    = '0;
        b_idx    = '0;
        a_addr   = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = PTR_W'((int'(ptr) + k) % NUM_SRC);
            if (rst && !bus.stall && bus.src_valid[scan_idx]) begin
                if (!a_vld) begin
                    a_vld  = 1'b1;
                    a_idx  = scan_idx;
                    a_addr = bus.src_addr[scan_idx];
                end else if (!b_vld && (bus.src_addr[scan_idx] != a_addr)) begin
                    b_vld = 1'b1;
                    b_idx = scan_idx;
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        if (a_vld) ready[a_idx] = 1'b1;
        if (b_vld) ready[b_idx] = 1'b1;
    end

    assign last_idx = b_vld ? b_idx : a_idx;
    assign ptr_nxt  = PTR_W'((int'(last_idx) + 1) % NUM_SRC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= '0;
            w1_en   <= 1'b0;
            w2_en   <= 1'b0;
            w1_addr <= '0;
            w2_addr <= '0;
            w1_dat  <= '0;
            w2_dat  <= '0;
        end else begin
            w1_en <= a_vld;
            w2_en <= b_vld;
            if (a_vld) begin
                w1_addr <= bus.src_addr[a_idx];
                w1_dat  <= bus.src_value[a_idx];
                ptr     <= ptr_nxt;
            end
            if (b_vld) begin
                w2_addr <= bus.src_addr[b_idx];
                w2_dat  <= bus.src_value[b_idx];
            end
        end
    end

    assign bus.src_ready     = ready;
    assign bus.write1        = w1_addr;
    assign bus.write1_enable = w1_en;
    assign bus.write1_value  = w1_dat;
    assign bus.write2        = w2_addr;
    assign bus.write2_enable = w2_en;
    assign bus.write2_value  = w2_dat;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a queue-based grant model.
module tb_regfile_wb_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;

    typedef struct packed {
        logic [DW-1:0] value;
    } data_t;

    typedef struct packed {
        logic  is_virtual;
        data_t data;
    } register_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regfile_wb_arbiter_if #(.NUM_SRC(N), .DATA_WIDTH(DW)) bus ();
    regfile_wb_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference state: pointer and the contents the write ports should hold.
    int         m_ptr;
    logic       m_e1, m_e2;
    logic [4:0] m_w1, m_w2;
    register_t  m_v1, m_v2;

    function automatic register_t rand_val();
        return register_t'({1'($urandom_range(1)), $urandom, $urandom});
    endfunction

    function automatic void model_grants(output int a, output int b);
        int order[$];
        a = -1;
        b = -1;
        if (!rst || bus.stall) return;
        for (int k = 0; k < N; k++)
            if (bus.src_valid[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
        if (order.size() == 0) return;
        a = order[0];
        foreach (order[j])
            if (j > 0 && b < 0 && bus.src_addr[order[j]] != bus.src_addr[a]) b = order[j];
    endfunction

    function automatic logic [N-1:0] grant_mask(input int a, input int b);
        logic [N-1:0] m = '0;
        if (a >= 0) m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [141:0] dut_out();
        return {bus.write1_enable, bus.write1, bus.write1_value,
                bus.write2_enable, bus.write2, bus.write2_value};
    endfunction

    function automatic logic [141:0] mdl_out();
        return {m_e1, m_w1, m_v1, m_e2, m_w2, m_v2};
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_e1 = 1'b0; m_e2 = 1'b0;
        m_w1 = '0;   m_w2 = '0;
        m_v1 = '0;   m_v2 = '0;
    endtask

    // One clock: grants decided from current inputs, model advanced at the edge, returns at the next negedge.
    task automatic tick(output int a, output int b);
        model_grants(a, b);
        @(posedge clk);
        m_e1 = (a >= 0);
        m_e2 = (b >= 0);
        if (a >= 0) begin m_w1 = bus.src_addr[a]; m_v1 = bus.src_value[a]; end
        if (b >= 0) begin m_w2 = bus.src_addr[b]; m_v2 = bus.src_value[b]; end
        if (a >= 0) m_ptr = ((b >= 0 ? b : a) + 1) % N;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int a, b;
        for (int i = 0; i < N; i++) begin
            bus.src_valid[i] = 1'b1;
            bus.src_addr[i]  = 5'(i + 1);
            bus.src_value[i] = rand_val();
        end
        #1 rst = 1'b0;
        #1;
        checks++; if (bus.src_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", bus.src_ready); end
        checks++; if (dut_out() !== 142'd0) begin errors++; $display("FAIL reset_outputs got %h exp 0", dut_out()); end
        checks++; if (dut.ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", dut.ptr); end
        @(negedge clk);
        checks++; if (dut_out() !== 142'd0) begin errors++; $display("FAIL reset_hold got %h exp 0", dut_out()); end
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (bus.src_ready !== 4'b0011) begin errors++; $display("FAIL release_ready got %b exp 0011", bus.src_ready); end
        tick(a, b);
        checks++; if (dut_out() !== mdl_out()) begin errors++; $display("FAIL release_out got %h exp %h", dut_out(), mdl_out()); end
        checks++; if ({bus.write1, bus.write2} !== {5'd1, 5'd2}) begin errors++; $display("FAIL release_addr got %0d/%0d exp 1/2", bus.write1, bus.write2); end
    endtask

    task automatic test_single();
        int a, b;
        bus.src_valid    = '0;
        bus.src_valid[2] = 1'b1;
        bus.src_addr[2]  = 5'd7;
        bus.src_value[2] = register_t'(65'h55);
        #1;
        checks++; if (bus.src_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", bus.src_ready); end
        tick(a, b);
        bus.src_valid = '0;
        checks++;
        if ({bus.write1_enable, bus.write1, bus.write1_value, bus.write2_enable} !== {1'b1, 5'd7, 65'h55, 1'b0}) begin
            errors++; $display("FAIL single_write got en1=%b a=%0d v=%h en2=%b exp 1/7/55/0",
                               bus.write1_enable, bus.write1, bus.write1_value, bus.write2_enable);
        end
        checks++; if (dut_out() !== mdl_out()) begin errors++; $display("FAIL single_out got %h exp %h", dut_out(), mdl_out()); end
    endtask

    task automatic test_fairness();
        int a, b;
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            bus.src_valid[i] = 1'b1;
            bus.src_addr[i]  = 5'(10 + i);
            bus.src_value[i] = rand_val();
        end
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++; if (dut.ptr !== 2'((c % 2) * 2)) begin errors++; $display("FAIL fair_ptr c=%0d got %0d exp %0d", c, dut.ptr, (c % 2) * 2); end
            checks++; if (bus.src_ready !== ((c % 2) ? 4'b1100 : 4'b0011)) begin errors++; $display("FAIL fair_ready c=%0d got %b", c, bus.src_ready); end
            tick(a, b);
            checks++; if (dut_out() !== mdl_out()) begin errors++; $display("FAIL fair_out c=%0d got %h exp %h", c, dut_out(), mdl_out()); end
            if (a >= 0) bus.src_value[a] = rand_val();
            if (b >= 0) bus.src_value[b] = rand_val();
            #1;
        end
        bus.src_valid = '0;
    endtask

    task automatic test_clash();
        int a, b;
        register_t v1;
        bus.src_valid = 4'b0111;
        bus.src_addr[0] = 5'd3; bus.src_addr[1] = 5'd3; bus.src_addr[2] = 5'd9;
        for (int i = 0; i < 3; i++) bus.src_value[i] = rand_val();
        v1 = bus.src_value[1];
        #1;
        checks++; if (bus.src_ready !== 4'b0101) begin errors++; $display("FAIL clash_ready got %b exp 0101", bus.src_ready); end
        tick(a, b);
        checks++; if ({bus.write1, bus.write2} !== {5'd3, 5'd9}) begin errors++; $display("FAIL clash_addr got %0d/%0d exp 3/9", bus.write1, bus.write2); end
        checks++; if (dut_out() !== mdl_out()) begin errors++; $display("FAIL clash_out got %h exp %h", dut_out(), mdl_out()); end
        bus.src_valid = 4'b0010;
        #1;
        checks++; if (bus.src_ready !== 4'b0010) begin errors++; $display("FAIL clash_retry_ready got %b exp 0010", bus.src_ready); end
        tick(a, b);
        checks++;
        if ({bus.write1_enable, bus.write1, bus.write1_value, bus.write2_enable} !== {1'b1, 5'd3, v1, 1'b0}) begin
            errors++; $display("FAIL clash_retry got en1=%b a=%0d v=%h en2=%b exp 1/3/%h/0",
                               bus.write1_enable, bus.write1, bus.write1_value, bus.write2_enable, v1);
        end
        bus.src_valid = '0;
    endtask

    task automatic test_stall();
        int a, b;
        int held;
        for (int i = 0; i < N; i++) begin
            bus.src_valid[i] = 1'b1;
            bus.src_addr[i]  = 5'(20 + i);
            bus.src_value[i] = rand_val();
        end
        bus.stall = 1'b1;
        held = m_ptr;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.src_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready c=%0d got %b exp 0000", c, bus.src_ready); end
            tick(a, b);
            checks++; if ({bus.write1_enable, bus.write2_enable} !== 2'b00) begin errors++; $display("FAIL stall_enables c=%0d got %b exp 00", c, {bus.write1_enable, bus.write2_enable}); end
            checks++; if (dut.ptr !== 2'(held)) begin errors++; $display("FAIL stall_ptr c=%0d got %0d exp %0d", c, dut.ptr, held); end
        end
        bus.stall = 1'b0;
        #1;
        model_grants(a, b);
        checks++; if (bus.src_ready !== grant_mask(a, b)) begin errors++; $display("FAIL stall_resume_ready got %b exp %b", bus.src_ready, grant_mask(a, b)); end
        tick(a, b);
        checks++; if (dut_out() !== mdl_out()) begin errors++; $display("FAIL stall_resume_out got %h exp %h", dut_out(), mdl_out()); end
        bus.src_valid = '0;
    endtask

    task automatic test_random();
        int a, b;
        for (int c = 0; c < 300; c++) begin
            bus.stall = ($urandom_range(9) == 0);
            for (int i = 0; i < N; i++) begin
                if (!bus.src_valid[i] && $urandom_range(2) != 0) begin
                    bus.src_valid[i] = 1'b1;
                    bus.src_addr[i]  = 5'($urandom_range(3));
                    bus.src_value[i] = rand_val();
                end
            end
            #1;
            model_grants(a, b);
            checks++; if (bus.src_ready !== grant_mask(a, b)) begin errors++; $display("FAIL rand_ready c=%0d got %b exp %b", c, bus.src_ready, grant_mask(a, b)); end
            tick(a, b);
            checks++; if (dut_out() !== mdl_out()) begin errors++; $display("FAIL rand_out c=%0d got %h exp %h", c, dut_out(), mdl_out()); end
            checks++; if (dut.ptr !== 2'(m_ptr)) begin errors++; $display("FAIL rand_ptr c=%0d got %0d exp %0d", c, dut.ptr, m_ptr); end
            checks++;
            if (bus.write1_enable && bus.write2_enable && bus.write1 === bus.write2) begin
                errors++; $display("FAIL rand_same_addr c=%0d got %0d/%0d exp distinct", c, bus.write1, bus.write2);
            end
            if (a >= 0) bus.src_valid[a] = 1'b0;
            if (b >= 0) bus.src_valid[b] = 1'b0;
        end
        bus.stall     = 1'b0;
        bus.src_valid = '0;
    endtask

    task automatic test_midreset();
        int a, b;
        for (int i = 0; i < N; i++) begin
            bus.src_valid[i] = 1'b1;
            bus.src_addr[i]  = 5'(1 + i);
            bus.src_value[i] = rand_val();
        end
        #1;
        tick(a, b);
        checks++; if (!bus.write1_enable) begin errors++; $display("FAIL mid_pre_enable got %b exp 1", bus.write1_enable); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({bus.write1_enable, bus.write2_enable} !== 2'b00) begin errors++; $display("FAIL mid_enables got %b exp 00", {bus.write1_enable, bus.write2_enable}); end
        checks++; if (bus.src_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready got %b exp 0000", bus.src_ready); end
        @(negedge clk);
        checks++; if (dut_out() !== 142'd0) begin errors++; $display("FAIL mid_hold got %h exp 0", dut_out()); end
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (bus.src_ready !== 4'b0011) begin errors++; $display("FAIL mid_release_ready got %b exp 0011", bus.src_ready); end
        tick(a, b);
        checks++; if (dut_out() !== mdl_out()) begin errors++; $display("FAIL mid_release_out got %h exp %h", dut_out(), mdl_out()); end
        checks++; if (bus.write1 !== 5'd1) begin errors++; $display("FAIL mid_release_addr got %0d exp 1", bus.write1); end
        bus.src_valid = '0;
    endtask

    initial begin
        bus.stall     = 1'b0;
        bus.src_valid = '0;
        bus.src_addr  = '0;
        bus.src_value = '0;
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_clash();
        test_stall();
        test_random();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
